// File: rtl/spi_byte_master_if.sv
// rtl/spi_byte_master_if.sv - command/response bundle between the APB-to-SPI bridge and the SPI byte engine
interface spi_byte_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - shared mode-0 SPI byte master, 24-bit opcode/addr/data frames on three address-decoded selects
// Optional: SPI_BYTE_MASTER_MISO_SYNC_EN adds a two-flop miso synchronizer.
module spi_byte_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned S1_MAX  = 90,
    parameter int unsigned S2_MAX  = 170
) (
    input  logic             clk,
    input  logic             reset,
    spi_byte_master_if.slave bus,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic [2:0]       cs_n
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic [4:0]  bit_q;
    logic        last_q;
    logic [22:0] tx_q;
    logic [7:0]  rx_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        sclk_q;
    logic        mosi_q;
    logic [2:0]  cs_n_q;

    logic [2:0]  sel_d;
    logic [23:0] frame_d;
    logic        div_end;
    logic        rise;

    always_comb begin
        sel_d = 3'b011;
        if (bus.cmd_addr <= 8'(S1_MAX)) begin
            sel_d = 3'b110;
        end else if (bus.cmd_addr <= 8'(S2_MAX)) begin
            sel_d = 3'b101;
        end
        frame_d = {7'b0000001, ~bus.cmd_write, bus.cmd_addr,
                   bus.cmd_write ? bus.cmd_data : 8'h00};
    end

    assign div_end = (div_q == DIV_LAST);
    // Clock edge on which sclk is driven high; this is the miso sample point.
    assign rise    = div_end && ((state_q == SETUP) ||
                                 (state_q == SHIFT && !sclk_q && !last_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= 8'd0;
            bit_q       <= 5'd0;
            last_q      <= 1'b0;
            tx_q        <= 23'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 3'b111;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                        div_q       <= 8'd0;
                        bit_q       <= 5'd0;
                        last_q      <= 1'b0;
                        cs_n_q      <= sel_d;
                        mosi_q      <= frame_d[23];
                        tx_q        <= frame_d[22:0];
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_q   <= 8'd0;
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_q <= 8'd0;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            if (bit_q == 5'd23) begin
                                last_q <= 1'b1;
                            end else begin
                                bit_q  <= bit_q + 5'd1;
                                mosi_q <= tx_q[22];
                                tx_q   <= {tx_q[21:0], 1'b0};
                            end
                        end else if (last_q) begin
                            state_q <= HOLD;
                        end else begin
                            sclk_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        div_q       <= 8'd0;
                        state_q     <= DONE;
                        cs_n_q      <= 3'b111;
                        mosi_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rx_q;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_BYTE_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync_q;
    logic [1:0] samp_q;

    // The strobe is delayed alongside the data so each sample still matches its sclk rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso_sync_q <= 2'b00;
            samp_q      <= 2'b00;
            rx_q        <= 8'h00;
        end else begin
            miso_sync_q <= {miso_sync_q[0], miso};
            samp_q      <= {samp_q[0], rise};
            if (samp_q[1]) begin
                rx_q <= {rx_q[6:0], miso_sync_q[1]};
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q <= 8'h00;
        end else if (rise) begin
            rx_q <= {rx_q[6:0], miso};
        end
    end
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign sclk          = sclk_q;
    assign mosi          = mosi_q;
    assign cs_n          = cs_n_q;
endmodule

// File: tb/tb_spi_byte_master.sv
// tb/tb_spi_byte_master.sv - randomized self-checking bench for spi_byte_master against a frame-level model
module tb_spi_byte_master;
`ifdef SPI_BYTE_MASTER_MISO_SYNC_EN
    localparam int D = 3;
`else
    localparam int D = 4;
`endif
    localparam int S1  = 90;
    localparam int S2  = 170;
    localparam int LAT = 50 * D + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       miso = 1'b0;
    logic       sclk;
    logic       mosi;
    logic [2:0] cs_n;

    spi_byte_master_if bus();

    spi_byte_master #(.CLK_DIV(D), .S1_MAX(S1), .S2_MAX(S2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso),
        .cs_n  (cs_n)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: target decode, frame contents, sclk level per cycle.
    function automatic logic [2:0] cs_of(input logic [7:0] a);
        int tgt;
        tgt = (int'(a) <= S1) ? 0 : (int'(a) <= S2) ? 1 : 2;
        return ~(3'b001 << tgt);
    endfunction

    function automatic logic [23:0] frame_of(input logic wr, input logic [7:0] a, input logic [7:0] d);
        return {wr ? 8'h02 : 8'h03, a, wr ? d : 8'h00};
    endfunction

    function automatic logic sclk_model(input int rel);
        int t;
        t = rel - 1 - D;
        if (t < 0 || t >= 48 * D) return 1'b0;
        return ((t / D) % 2) == 0;
    endfunction

    // Mode-0 slave: presents miso MSB first, shifts on falling sclk, captures mosi on rising sclk.
    logic [23:0] slv_tx = '0;
    logic [23:0] slv_rx = '0;
    int          slv_cnt = 0;
    int          cs_bad = 0;
    logic [2:0]  exp_cs = 3'b111;
    logic        sclk_prev = 1'b0;
    logic        cs_hi_prev = 1'b1;

    always @(sclk or cs_n) begin
        if (cs_hi_prev && !(&cs_n)) begin
            slv_cnt = 0;
            slv_rx  = '0;
            miso    = slv_tx[23];
        end else if (sclk && !sclk_prev) begin
            slv_rx = {slv_rx[22:0], mosi};
            slv_cnt++;
            if (cs_n !== exp_cs) cs_bad++;
        end else if (!sclk && sclk_prev && slv_cnt < 24) begin
            miso = slv_tx[23 - slv_cnt];
        end
        sclk_prev  = sclk;
        cs_hi_prev = &cs_n;
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.cmd_ready), 1);
    endtask

    task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           input logic [23:0] pat, input int abort_at);
        int acc, rel, first_rise, cs_dev, bad0, n;
        logic [2:0] ecs;
        ecs = cs_of(a);
        exp_cs = ecs;
        slv_tx = pat;
        bad0 = cs_bad;
        first_rise = 0;
        cs_dev = 0;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        acc = cyc_cnt + 1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_data  = 8'($urandom);
        check("cs_at_cycle1", 32'(cs_n), 32'(ecs));
        check("ready_busy", 32'(bus.cmd_ready), 0);
        rel = 1;
        while (bus.rsp_valid !== 1'b1 && rel < LAT + 20) begin
            if (rel == abort_at) begin
                check("sclk_pre_abort", 32'(sclk), 32'(sclk_model(rel)));
                reset = 1'b1;
                #1;
                check("abort_cs", 32'(cs_n), 32'h7);
                check("abort_sclk", 32'(sclk), 0);
                check("abort_mosi", 32'(mosi), 0);
                check("abort_rsp", 32'(bus.rsp_valid), 0);
                repeat (2) begin
                    @(negedge clk);
                    check("ready_in_reset", 32'(bus.cmd_ready), 0);
                end
                reset = 1'b0;
                @(negedge clk);
                check("ready_after_reset", 32'(bus.cmd_ready), 1);
                n = 0;
                repeat (LAT + 10) begin
                    @(negedge clk);
                    if (bus.rsp_valid === 1'b1 || !(&cs_n)) n++;
                end
                check("no_rsp_after_abort", n, 0);
                return;
            end
            if (sclk === 1'b1 && first_rise == 0) first_rise = rel;
            if (cs_n !== ecs) cs_dev++;
            @(negedge clk);
            rel = cyc_cnt - acc + 1;
        end
        check("rsp_latency", rel, LAT);
        check("rsp_data", 32'(bus.rsp_data), 32'(pat[7:0]));
        check("mosi_frame", 32'(slv_rx), 32'(frame_of(wr, a, d)));
        check("sclk_rises", slv_cnt, 24);
        check("first_sclk_rise", first_rise, 1 + D);
        check("cs_held", cs_dev, 0);
        check("cs_at_rises", cs_bad - bad0, 0);
        check("cs_released", 32'(cs_n), 32'h7);
        @(negedge clk);
        check("rsp_pulse", 32'(bus.rsp_valid), 0);
        check("ready_after_done", 32'(bus.cmd_ready), 1);
        check("rsp_held", 32'(bus.rsp_data), 32'(pat[7:0]));
    endtask

    task automatic b2b(input logic [7:0] a1, input logic [7:0] a2,
                       input logic [23:0] p1, input logic [23:0] p2);
        int acc1, acc2, frames, gap, min_gap, rsps, n, extra, bad0;
        logic       hi_prev;
        logic [2:0] cs2;
        exp_cs = cs_of(a1);
        slv_tx = p1;
        bad0 = cs_bad;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = a1;
        bus.cmd_data  = 8'($urandom);
        acc1 = cyc_cnt + 1;
        acc2 = -1;
        @(negedge clk);
        bus.cmd_addr = a2;
        frames = 0; gap = 0; min_gap = 1000; rsps = 0; n = 0;
        hi_prev = 1'b1;
        cs2 = 3'b111;
        while (rsps < 2 && n < 2 * LAT + 20) begin
            if (acc2 >= 0) bus.cmd_valid = 1'b0;
            else if (bus.cmd_ready === 1'b1) acc2 = cyc_cnt + 1;
            if (&cs_n) begin
                gap++;
            end else begin
                if (hi_prev) begin
                    frames++;
                    if (frames == 2) begin
                        cs2 = cs_n;
                        if (gap < min_gap) min_gap = gap;
                    end
                end
                gap = 0;
            end
            hi_prev = &cs_n;
            if (bus.rsp_valid === 1'b1) begin
                rsps++;
                if (rsps == 1) begin
                    check("b2b_rsp1", 32'(bus.rsp_data), 32'(p1[7:0]));
                    check("b2b_frame1", 32'(slv_rx), 32'(frame_of(1'b0, a1, 8'h00)));
                    slv_tx = p2;
                    exp_cs = cs_of(a2);
                end else begin
                    check("b2b_rsp2", 32'(bus.rsp_data), 32'(p2[7:0]));
                    check("b2b_frame2", 32'(slv_rx), 32'(frame_of(1'b0, a2, 8'h00)));
                end
            end
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (!(&cs_n)) extra++;
        end
        check("b2b_rsps", rsps, 2);
        check("b2b_frames", frames, 2);
        check("b2b_no_third", extra, 0);
        check("b2b_spacing", acc2 - acc1, LAT + 1);
        check("b2b_cs_gap_ok", 32'(min_gap >= 1), 1);
        check("b2b_cs2", 32'(cs2), 32'(cs_of(a2)));
        check("b2b_cs_at_rises", cs_bad - bad0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rd;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_data  = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cs", 32'(cs_n), 32'h7);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        check("rst_ready", 32'(bus.cmd_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_rises", 32'(bus.cmd_ready), 1);

        run_cmd(1'b1, 8'h10, 8'hA5, 24'($urandom), 0);
        run_cmd(1'b0, 8'h5B, 8'h00, {16'($urandom), 8'h3C}, 0);
        run_cmd(1'b0, 8'd90,  8'h00, 24'($urandom), 0);
        run_cmd(1'b0, 8'd170, 8'h00, 24'($urandom), 0);
        run_cmd(1'b0, 8'd171, 8'h00, 24'($urandom), 0);
        run_cmd(1'b0, 8'd255, 8'h00, 24'($urandom), 0);
        run_cmd(1'b0, 8'h20,  8'h00, {16'($urandom), 8'hC3}, 0);

        b2b(8'd30, 8'd200, 24'($urandom), 24'($urandom));

        run_cmd(1'b1, 8'h40, 8'h99, 24'($urandom), 60);
        run_cmd(1'b1, 8'hB0, 8'h66, 24'($urandom), 11 * D + 2);
        run_cmd(1'b1, 8'h10, 8'hA5, 24'($urandom), 0);

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rd = 8'($urandom);
            run_cmd(1'($urandom), ra, rd, 24'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
